// File: rtl/output_mem_sched_pkg.sv
// Shared constants, state encoding and timestep codes
// for the output-memory readout scheduler.
package output_mem_sched_pkg;

  localparam int DEPTH_C   = 441;
  localparam int ADDR_C    = 9;
  localparam int CONV_W    = 13;
  localparam int THRESHOLD = 64;

  localparam logic [1:0] TS1 = 2'd1;
  localparam logic [1:0] TS2 = 2'd2;

  typedef enum logic [3:0] {
    S_FILL,
    S_START,
    S_RD1,
    S_EV1,
    S_OUT1,
    S_RD2A,
    S_RD2B,
    S_EV2,
    S_OUT2,
    S_DONE
  } state_e;

endpackage

// File: rtl/output_mem_thresh.sv
// Threshold helper: strict compare, subtract on spike.
// Pure combinational, shared by both evaluate states.
module output_mem_thresh
  import output_mem_sched_pkg::*;
#(
  parameter int W = CONV_W
) (
  input  logic [W-1:0] i_value,
  input  logic [W-1:0] i_thresh,
  output logic         o_spike,
  output logic [W-1:0] o_residue
);

  always_comb begin
    o_spike   = (i_value > i_thresh);
    o_residue = i_value;
    if (o_spike) begin
      o_residue = i_value - i_thresh;
    end
  end

endmodule

// File: rtl/output_mem_sched.sv
// Fills two residue banks, then streams ts1 and ts2
// spikes while writing residues back in place.
module output_mem_sched
  import output_mem_sched_pkg::*;
#(
  parameter int DEPTH_C   = output_mem_sched_pkg::DEPTH_C,
  parameter int ADDR_C    = output_mem_sched_pkg::ADDR_C,
  parameter int CONV_W    = output_mem_sched_pkg::CONV_W,
  parameter int THRESHOLD = output_mem_sched_pkg::THRESHOLD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              wr_ts,
  input  logic [ADDR_C-1:0] wr_addr,
  input  logic [CONV_W-1:0] wr_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic              mem_bank,
  output logic [ADDR_C-1:0] mem_addr,
  output logic [CONV_W-1:0] mem_wdata,
  input  logic [CONV_W-1:0] mem_rdata,
  output logic              spk_valid,
  input  logic              spk_ready,
  output logic [1:0]        spk_ts,
  output logic [ADDR_C-1:0] spk_addr,
  output logic              spk_data,
  output logic              start_r,
  output logic              done_r,
  output logic              busy
);

  localparam int CNT_W = $clog2(DEPTH_C + 1);
  localparam logic [CNT_W-1:0] L_DEPTH =
    CNT_W'(DEPTH_C);
  localparam logic [ADDR_C-1:0] L_LAST =
    ADDR_C'(DEPTH_C - 1);
  localparam logic [CONV_W-1:0] L_THR =
    CONV_W'(THRESHOLD);

  state_e r_state;
  state_e w_next;

  logic [CNT_W-1:0]  r_cnt0;
  logic [CNT_W-1:0]  r_cnt1;
  logic [ADDR_C-1:0] r_i;
  logic [CONV_W-1:0] r_res0;
  logic              r_spk;

  logic              w_wr_fire;
  logic              w_spk_fire;
  logic              w_full;
  logic [CONV_W:0]   w_sum;
  logic [CONV_W-1:0] w_sat;
  logic [CONV_W-1:0] w_val;
  logic [CONV_W-1:0] w_res;
  logic              w_spike;

  assign w_full = (r_cnt0 == L_DEPTH) &&
                  (r_cnt1 == L_DEPTH);

  always_comb begin
    wr_ready = 1'b0;
    if (r_state == S_FILL) begin
      if (wr_ts) wr_ready = (r_cnt1 < L_DEPTH);
      else       wr_ready = (r_cnt0 < L_DEPTH);
    end
  end

  assign w_wr_fire  = wr_valid & wr_ready;
  assign w_spk_fire = spk_valid & spk_ready;

  // EV2 evaluates the saturated ts1-residue + ts2-psum
  assign w_sum = {1'b0, r_res0} + {1'b0, mem_rdata};
  assign w_sat = w_sum[CONV_W] ? '1
                                : w_sum[CONV_W-1:0];
  assign w_val = (r_state == S_EV2) ? w_sat
                                     : mem_rdata;

  output_mem_thresh #(
    .W (CONV_W)
  ) u_thresh (
    .i_value   (w_val),
    .i_thresh  (L_THR),
    .o_spike   (w_spike),
    .o_residue (w_res)
  );

  assign spk_valid = (r_state == S_OUT1) ||
                     (r_state == S_OUT2);
  assign spk_ts    = (r_state == S_OUT2) ? TS2 : TS1;
  assign spk_addr  = r_i;
  assign spk_data  = r_spk;
  assign start_r   = (r_state == S_START);
  assign done_r    = (r_state == S_DONE);
  assign busy      = (r_state != S_FILL);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FILL:  if (w_full) w_next = S_START;
      S_START: w_next = S_RD1;
      S_RD1:   w_next = S_EV1;
      S_EV1:   w_next = S_OUT1;
      S_OUT1: begin
        if (spk_ready) begin
          w_next = (r_i < L_LAST) ? S_RD1 : S_RD2A;
        end
      end
      S_RD2A:  w_next = S_RD2B;
      S_RD2B:  w_next = S_EV2;
      S_EV2:   w_next = S_OUT2;
      S_OUT2: begin
        if (spk_ready) begin
          w_next = (r_i < L_LAST) ? S_RD2A : S_DONE;
        end
      end
      S_DONE:  w_next = S_FILL;
      default: w_next = S_FILL;
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_bank  = 1'b0;
    mem_addr  = r_i;
    mem_wdata = w_res;
    unique case (r_state)
      S_FILL: begin
        mem_en    = w_wr_fire;
        mem_we    = w_wr_fire;
        mem_bank  = wr_ts;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
      end
      S_RD1, S_RD2A: mem_en = 1'b1;
      S_EV1: begin
        mem_en = 1'b1;
        mem_we = 1'b1;
      end
      S_RD2B: begin
        mem_en   = 1'b1;
        mem_bank = 1'b1;
      end
      S_EV2: begin
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        mem_bank = 1'b1;
      end
      default: mem_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FILL;
      r_cnt0  <= '0;
      r_cnt1  <= '0;
      r_i     <= '0;
      r_res0  <= '0;
      r_spk   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_wr_fire) begin
        if (wr_ts) r_cnt1 <= r_cnt1 + CNT_W'(1);
        else       r_cnt0 <= r_cnt0 + CNT_W'(1);
      end
      if (r_state == S_DONE) begin
        r_cnt0 <= '0;
        r_cnt1 <= '0;
      end
      if (r_state == S_START) r_i <= '0;
      if (w_spk_fire) begin
        if (r_i < L_LAST) begin
          r_i <= r_i + ADDR_C'(1);
        end else if (r_state == S_OUT1) begin
          r_i <= '0;
        end
      end
      if (r_state == S_RD2B) r_res0 <= mem_rdata;
      if ((r_state == S_EV1) || (r_state == S_EV2)) begin
        r_spk <= w_spike;
      end
    end
  end

endmodule
